bch_llr_loader: RTL and testbench
=================================

BCH_LLR_LOADER -- requirements
Module: bch_llr_loader

Interface
REQ-001 Parameters SHALL be, one per line: N_MAX, 1023, maximum codeword length in bits; LLR_W, 8, LLR sample width (two's complement).
REQ-002 Ports SHALL be, one per line:
  clk  in  1  clock
  rstn  in  1  reset, synchronous, active-low
  frame_start  in  1  one-cycle pulse, begins a frame; sampled only in S_IDLE
  n_in  in  10  codeword length (1..N_MAX)
  t_in  in  4  correction capability
  m_in  in  4  field degree
  llr_valid  in  1  LLR sample valid
  llr_data  in  LLR_W  signed LLR sample
  llr_ready  out  1  loader accepts a sample this cycle
  core_start  out  1  one-cycle start pulse to hard-decision core
  core_n  out  10  latched n to core
  core_t  out  4  latched t to core
  core_m  out  4  latched m to core
  hard_bits  out  N_MAX  packed hard decisions to core
  core_done  in  1  one-cycle done pulse from core
  busy  out  1  high in any state other than S_IDLE

Function
REQ-003 States SHALL be S_IDLE, S_LOAD, S_FIRE, S_WAIT.
REQ-004 S_IDLE with frame_start=1 SHALL latch n_in/t_in/m_in into core_n/core_t/core_m, clear hard_bits to all zeros, clear the sample counter cnt to 0, and go to S_LOAD next cycle.
REQ-005 frame_start SHALL be ignored in any state other than S_IDLE.
REQ-006 llr_ready SHALL equal 1 exactly when state is S_LOAD; a sample is accepted on a cycle where llr_valid and llr_ready are both 1.
REQ-007 On acceptance, hard decision SHALL be the sign bit of llr_data (1 if negative, 0 if zero or positive), written to hard_bits[cnt], after which cnt increments by 1.
REQ-008 cnt SHALL be 10 bits; hard_bits[i] for i >= core_n SHALL remain 0.
REQ-009 Accepting the sample with cnt == core_n-1 SHALL move to S_FIRE next cycle; no further samples are accepted in that frame.
REQ-010 S_FIRE SHALL last exactly one cycle with core_start=1, then go to S_WAIT; core_start SHALL be 0 in every other state.
REQ-011 Latency: core_start SHALL assert exactly 1 cycle after the cycle in which the last sample is accepted.
REQ-012 S_WAIT SHALL hold hard_bits and core_n/t/m stable and return to S_IDLE on the cycle after core_done=1.
REQ-013 core_done outside S_WAIT SHALL be ignored.
REQ-014 llr_valid gaps in S_LOAD SHALL stall cnt without other effect (no timeout).
REQ-015 frame_start and core_done arriving in the same cycle in S_WAIT: core_done SHALL be taken, frame_start ignored; a new frame requires frame_start in S_IDLE.
REQ-016 n_in values of 0 or greater than N_MAX SHALL be clamped: 0 treated as 1, values above N_MAX treated as N_MAX, at latch time.
REQ-017 hard_bits and core_n/t/m SHALL retain their values in S_IDLE after a frame until the next frame_start.

Reset
REQ-018 With rstn=0 at a clock edge: state=S_IDLE, cnt=0, hard_bits=0, core_n/core_t/core_m=0, core_start=0, llr_ready=0, busy=0.
REQ-019 Reset asserted mid-frame (S_LOAD, S_FIRE or S_WAIT) SHALL abort the frame with no core_start pulse issued afterwards.

Verification
REQ-020 n=7, LLRs +5,-3,0,-128,+127,-1,+2 back-to-back -> hard_bits[6:0]=7'b0101010, bits [N_MAX-1:7]=0, core_start high 1 cycle after 7th acceptance.
REQ-021 n=1023, llr_valid toggling 1/0 each cycle, all samples -1 -> hard_bits all ones, exactly 1023 acceptances, single core_start pulse.
REQ-022 frame_start pulsed during S_LOAD and S_WAIT -> no effect on cnt, latched config or state.
REQ-023 n_in=0 -> one sample accepted then core_start; n_in=1023 with N_MAX=1023 unaffected.
REQ-024 rstn low at cnt=3 of n=15 frame -> all outputs at reset values next cycle, no core_start; next frame n=4 loads cleanly.
REQ-025 core_done in S_WAIT -> busy=0 and S_IDLE next cycle; core_done while in S_LOAD -> ignored, loading continues.

Source files
------------

// File: rtl/bch_llr_loader.sv
`default_nettype none
// ============================================================================
// Module   : bch_llr_loader
// Purpose  : Collects one frame of signed LLR samples, converts each to a hard
//            decision (sign bit), packs them into a codeword-wide vector and
//            hands the frame to the BCH hard-decision core with a start pulse.
//            Holds the vector and the latched frame configuration until the
//            core reports done.
// Ports    :
//   clk          in   clock
//   rstn         in   synchronous active-low reset
//   frame_start  in   begins a frame (honoured only when idle)
//   n_in         in   codeword length, clamped to 1..N_MAX when latched
//   t_in, m_in   in   correction capability / field degree
//   llr_valid    in   LLR sample valid
//   llr_data     in   signed LLR sample
//   llr_ready    out  loader is accepting samples
//   core_start   out  one-cycle start pulse to the core
//   core_n/t/m   out  latched frame configuration
//   hard_bits    out  packed hard decisions, bit i = sample i
//   core_done    in   one-cycle done pulse from the core (honoured in S_WAIT)
//   busy         out  high whenever a frame is in progress
// Revision : 1.0  initial release
// ============================================================================
module bch_llr_loader #(
   parameter int N_MAX = 1023,
   parameter int LLR_W = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             frame_start,
   input  logic [9:0]       n_in,
   input  logic [3:0]       t_in,
   input  logic [3:0]       m_in,
   input  logic             llr_valid,
   input  logic [LLR_W-1:0] llr_data,
   output logic             llr_ready,
   output logic             core_start,
   output logic [9:0]       core_n,
   output logic [3:0]       core_t,
   output logic [3:0]       core_m,
   output logic [N_MAX-1:0] hard_bits,
   input  logic             core_done,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_FIRE = 2'd2,
      S_WAIT = 2'd3
   } state_t;

   // 11 bits so the "greater than N_MAX" test cannot wrap for N_MAX = 1023.
   localparam logic [10:0] c_N_MAX = 11'(N_MAX);

   state_t             r_state;
   logic [9:0]         r_cnt;
   logic [9:0]         r_core_n;
   logic [3:0]         r_core_t;
   logic [3:0]         r_core_m;
   logic [N_MAX-1:0]   r_hard_bits;
   logic               r_core_start;
   logic               r_llr_ready;
   logic               r_busy;
   logic [9:0]         w_n_clamp;

   // Length 0 is treated as 1 and anything beyond N_MAX as N_MAX, so the
   // terminal-count compare in S_LOAD always has a reachable target.
   always_comb begin
      w_n_clamp = n_in;
      if (n_in == 10'd0) begin
         w_n_clamp = 10'd1;
      end else if ({1'b0, n_in} > c_N_MAX) begin
         w_n_clamp = c_N_MAX[9:0];
      end
   end

   // Single state register; every output flag is updated on the same edge
   // as the transition that implies it, so all outputs come from flops.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_core_n     <= '0;
         r_core_t     <= '0;
         r_core_m     <= '0;
         r_hard_bits  <= '0;
         r_core_start <= 1'b0;
         r_llr_ready  <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_core_start <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (frame_start) begin
                  r_core_n    <= w_n_clamp;
                  r_core_t    <= t_in;
                  r_core_m    <= m_in;
                  r_hard_bits <= '0;
                  r_cnt       <= '0;
                  r_llr_ready <= 1'b1;
                  r_busy      <= 1'b1;
                  r_state     <= S_LOAD;
               end
            end
            S_LOAD: begin
               // Ready is high throughout S_LOAD, so valid alone is a handshake.
               if (llr_valid) begin
                  r_hard_bits[r_cnt] <= llr_data[LLR_W-1];
                  r_cnt              <= r_cnt + 10'd1;
                  if (r_cnt == r_core_n - 10'd1) begin
                     r_llr_ready  <= 1'b0;
                     r_core_start <= 1'b1;
                     r_state      <= S_FIRE;
                  end
               end
            end
            S_FIRE: begin
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (core_done) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_llr_ready <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign llr_ready  = r_llr_ready;
   assign core_start = r_core_start;
   assign core_n     = r_core_n;
   assign core_t     = r_core_t;
   assign core_m     = r_core_m;
   assign hard_bits  = r_hard_bits;
   assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_bch_llr_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_bch_llr_loader
// Purpose  : Scoreboard bench for bch_llr_loader. Each frame pushes its
//            expected vector/config/acceptance count; a negedge monitor pops
//            and checks on every core_start pulse.
// Revision : 1.0  initial release
// ============================================================================
module tb_bch_llr_loader;

   localparam int N = 1023;

   logic          clk = 1'b0;
   logic          rstn;
   logic          frame_start;
   logic [9:0]    n_in;
   logic [3:0]    t_in;
   logic [3:0]    m_in;
   logic          llr_valid;
   logic [7:0]    llr_data;
   logic          llr_ready;
   logic          core_start;
   logic [9:0]    core_n;
   logic [3:0]    core_t;
   logic [3:0]    core_m;
   logic [N-1:0]  hard_bits;
   logic          core_done;
   logic          busy;

   bch_llr_loader #(.N_MAX(N), .LLR_W(8)) u_dut (
      .clk         (clk),
      .rstn        (rstn),
      .frame_start (frame_start),
      .n_in        (n_in),
      .t_in        (t_in),
      .m_in        (m_in),
      .llr_valid   (llr_valid),
      .llr_data    (llr_data),
      .llr_ready   (llr_ready),
      .core_start  (core_start),
      .core_n      (core_n),
      .core_t      (core_t),
      .core_m      (core_m),
      .hard_bits   (hard_bits),
      .core_done   (core_done),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] bits;
      logic [9:0]   n;
      logic [3:0]   t;
      logic [3:0]   m;
      int           acc;
   } exp_t;

   exp_t       sb[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc     = 0;
   int         acc_cnt = 0;
   int         last_acc = -10;
   logic [7:0] samp [0:N-1];

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: counts acceptances and checks every core_start against the queue.
   always @(negedge clk) begin
      exp_t e;
      if (!rstn) begin
         acc_cnt = 0;
      end else begin
         if (llr_valid && llr_ready) begin
            acc_cnt++;
            last_acc = cyc;
         end
         if (core_start) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_core_start: got pulse at cycle %0d, expected none", cyc);
            end else begin
               e = sb.pop_front();
               chk("hard_bits",     hard_bits, e.bits);
               chk("core_n",        N'(core_n), N'(e.n));
               chk("core_t",        N'(core_t), N'(e.t));
               chk("core_m",        N'(core_m), N'(e.m));
               chk("acceptances",   N'(acc_cnt), N'(e.acc));
               chk("start_latency", N'(cyc), N'(last_acc + 1));
            end
            acc_cnt = 0;
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Runs one frame up to the core_start pulse.
   task automatic run_frame(input logic [9:0] n_req, input int n_eff,
                            input logic [3:0] t, input logic [3:0] m,
                            input bit gaps, input bit disturb);
      exp_t e;
      int   k;
      e.bits = '0;
      for (int i = 0; i < n_eff; i++) e.bits[i] = samp[i][7];
      e.n   = n_eff[9:0];
      e.t   = t;
      e.m   = m;
      e.acc = n_eff;
      sb.push_back(e);
      frame_start = 1'b1; n_in = n_req; t_in = t; m_in = m;
      tick();
      frame_start = 1'b0; n_in = 10'h3AA; t_in = ~t; m_in = ~m;
      for (int i = 0; i < n_eff; i++) begin
         if (gaps) begin
            llr_valid = 1'b0; llr_data = 8'h80;
            tick();
         end
         llr_valid = 1'b1; llr_data = samp[i];
         if (disturb && i == 2) begin
            frame_start = 1'b1; core_done = 1'b1;
         end
         tick();
         frame_start = 1'b0; core_done = 1'b0;
      end
      llr_valid = 1'b0; llr_data = 8'h80;
      k = 0;
      while (!core_start && k < 8) begin
         tick();
         k++;
      end
      if (!core_start) begin
         n_tests++;
         n_fail++;
         $display("FAIL core_start_timeout: got no pulse in %0d cycles, expected pulse", k);
      end
   endtask

   // Waits in S_WAIT, optionally pokes frame_start, then completes with core_done.
   task automatic finish_frame(input logic [9:0] exp_n, input bit wait_poke, input bit same_cycle);
      tick();
      chk("busy_in_wait", N'(busy), N'(1'b1));
      if (wait_poke) begin
         frame_start = 1'b1; n_in = 10'd5;
         tick();
         frame_start = 1'b0;
         tick();
         chk("wait_poke_core_n", N'(core_n), N'(exp_n));
         chk("wait_poke_busy",   N'(busy),   N'(1'b1));
      end
      core_done = 1'b1;
      if (same_cycle) frame_start = 1'b1;
      tick();
      core_done = 1'b0; frame_start = 1'b0;
      chk("done_busy",  N'(busy),      N'(1'b0));
      chk("done_ready", N'(llr_ready), N'(1'b0));
      tick();
      chk("idle_stays", N'(busy),      N'(1'b0));
   endtask

   initial begin
      rstn = 1'b0; frame_start = 1'b0; n_in = '0; t_in = '0; m_in = '0;
      llr_valid = 1'b0; llr_data = '0; core_done = 1'b0;
      repeat (3) tick();
      chk("rst_ready",      N'(llr_ready),  '0);
      chk("rst_busy",       N'(busy),       '0);
      chk("rst_core_start", N'(core_start), '0);
      chk("rst_hard_bits",  hard_bits,      '0);
      chk("rst_core_n",     N'(core_n),     '0);
      chk("rst_core_tm",    N'({core_t, core_m}), '0);
      rstn = 1'b1;
      tick();

      // n=7: +5,-3,0,-128,+127,-1,+2, plus frame_start poke in S_WAIT
      samp[0] = 8'h05; samp[1] = 8'hFD; samp[2] = 8'h00; samp[3] = 8'h80;
      samp[4] = 8'h7F; samp[5] = 8'hFF; samp[6] = 8'h02;
      run_frame(10'd7, 7, 4'd3, 4'd10, 1'b0, 1'b0);
      finish_frame(10'd7, 1'b1, 1'b0);
      chk("n7_retained_bits", hard_bits, N'(7'b0101010));
      chk("n7_retained_n",    N'(core_n), N'(10'd7));

      // n=9 with frame_start and core_done poked mid-load; done + frame_start together
      samp[0] = 8'h01; samp[1] = 8'hFE; samp[2] = 8'h7F; samp[3] = 8'h80; samp[4] = 8'h00;
      samp[5] = 8'hC0; samp[6] = 8'h40; samp[7] = 8'hFF; samp[8] = 8'h10;
      run_frame(10'd9, 9, 4'd5, 4'd9, 1'b0, 1'b1);
      finish_frame(10'd9, 1'b0, 1'b1);
      chk("n9_retained_bits", hard_bits, N'(9'b010101010));

      // n=1023, all -1, valid toggling
      for (int i = 0; i < N; i++) samp[i] = 8'hFF;
      run_frame(10'd1023, 1023, 4'd12, 4'd10, 1'b1, 1'b0);
      finish_frame(10'd1023, 1'b0, 1'b0);
      chk("n1023_all_ones", hard_bits, {N{1'b1}});

      // n_in=0 clamps to a single sample
      samp[0] = 8'hFB;
      run_frame(10'd0, 1, 4'd1, 4'd4, 1'b0, 1'b0);
      finish_frame(10'd1, 1'b0, 1'b0);
      chk("n0_bits", hard_bits, N'(1'b1));

      // reset at cnt=3 of an n=15 frame
      frame_start = 1'b1; n_in = 10'd15; t_in = 4'd2; m_in = 4'd4;
      tick();
      frame_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         llr_valid = 1'b1; llr_data = 8'hFF;
         tick();
      end
      llr_valid = 1'b0; rstn = 1'b0;
      tick();
      chk("abort_ready",      N'(llr_ready),  '0);
      chk("abort_busy",       N'(busy),       '0);
      chk("abort_core_start", N'(core_start), '0);
      chk("abort_hard_bits",  hard_bits,      '0);
      chk("abort_cfg",        N'({core_n, core_t, core_m}), '0);
      rstn = 1'b1;
      repeat (6) tick();

      // clean n=4 frame after the abort
      samp[0] = 8'h01; samp[1] = 8'hFF; samp[2] = 8'hF0; samp[3] = 8'h01;
      run_frame(10'd4, 4, 4'd2, 4'd4, 1'b0, 1'b0);
      finish_frame(10'd4, 1'b0, 1'b0);
      chk("n4_bits", hard_bits, N'(4'b0110));

      repeat (3) tick();
      chk("scoreboard_empty", N'(sb.size()), '0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion by 500000 ns, expected finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
